// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern colour generator for a VGA output.
//   A debounced push-button steps through four patterns: colour bars, checkerboard,
//   a bouncing box, and a solid colour that cycles once per frame.
// Ports:
//   clk, rst_n              system clock, async active-low reset
//   pix_en                  one-clk pulse per pixel; the pixel path advances on it
//   hsync_in, vsync_in      active-low syncs aligned with x_in/y_in
//   x_in, y_in              pixel coordinates, 1-based when active, 0 = blanking
//   btn_c                   raw asynchronous push-button, active-high
//   VGA_HS, VGA_VS          syncs delayed by one pix_en
//   VGA_R, VGA_G, VGA_B     registered pixel colour
//   mode                    current pattern mode
module vga_pattern_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BOX_SIZE        = 32,
  parameter int unsigned H_ACT           = 640,
  parameter int unsigned V_ACT           = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] x_in,
  input  logic [8:0] y_in,
  input  logic       btn_c,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic [1:0] mode
);

  localparam int unsigned XW    = 11;
  localparam int unsigned YW    = 10;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BOX     = 2'd2,
    MODE_SOLID   = 2'd3
  } mode_t;

  logic             r_btn_meta;
  logic             r_btn_sync;
  logic             r_btn_stable;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_press;
  mode_t            r_mode;
  mode_t            w_mode_next;
  logic             r_vs_prev;
  logic             r_vs_armed;
  logic             w_frame_tick;
  logic [9:0]       r_box_x;
  logic [8:0]       r_box_y;
  logic             r_dir_x;   // 1 = moving towards larger coordinates
  logic             r_dir_y;
  logic             w_hit_right;
  logic             w_hit_left;
  logic             w_hit_bottom;
  logic             w_hit_top;
  logic [11:0]      r_solid;
  logic [2:0]       w_bar;
  logic             w_x_b5;
  logic             w_y_b5;
  logic             w_in_box;
  logic [11:0]      w_rgb;
  logic [11:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_btn_meta <= btn_c;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_stable <= 1'b0;
      r_db_cnt     <= '0;
      r_press      <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_btn_sync == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_stable <= r_btn_sync;
        r_db_cnt     <= '0;
        r_press      <= r_btn_sync;  // only the rising level is an event
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  // Mode FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mode <= MODE_BARS;
    else        r_mode <= w_mode_next;
  end

  // Mode FSM next state
  always_comb begin
    w_mode_next = r_mode;
    if (r_press) begin
      case (r_mode)
        MODE_BARS:    w_mode_next = MODE_CHECKER;
        MODE_CHECKER: w_mode_next = MODE_BOX;
        MODE_BOX:     w_mode_next = MODE_SOLID;
        default:      w_mode_next = MODE_BARS;
      endcase
    end
  end

  // Frame tick on vsync falling edge; suppressed for the first sample after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_prev  <= 1'b1;
      r_vs_armed <= 1'b0;
    end else begin
      r_vs_prev  <= vsync_in;
      r_vs_armed <= 1'b1;
    end
  end

  assign w_frame_tick = r_vs_armed & r_vs_prev & ~vsync_in;

  assign w_hit_right  = (XW'(r_box_x) + XW'(BOX_SIZE - 1)) >= XW'(H_ACT);
  assign w_hit_left   = r_box_x <= 10'd1;
  assign w_hit_bottom = (YW'(r_box_y) + YW'(BOX_SIZE - 1)) >= YW'(V_ACT);
  assign w_hit_top    = r_box_y <= 9'd1;

  // Bouncing box; r_mode here is the pre-press value when both events coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box_x <= 10'd1;
      r_box_y <= 9'd1;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_frame_tick && (r_mode == MODE_BOX)) begin
      if (r_dir_x) begin
        if (w_hit_right) begin
          r_dir_x <= 1'b0;
          r_box_x <= r_box_x - 10'd1;
        end else begin
          r_box_x <= r_box_x + 10'd1;
        end
      end else if (w_hit_left) begin
        r_dir_x <= 1'b1;
        r_box_x <= r_box_x + 10'd1;
      end else begin
        r_box_x <= r_box_x - 10'd1;
      end
      if (r_dir_y) begin
        if (w_hit_bottom) begin
          r_dir_y <= 1'b0;
          r_box_y <= r_box_y - 9'd1;
        end else begin
          r_box_y <= r_box_y + 9'd1;
        end
      end else if (w_hit_top) begin
        r_dir_y <= 1'b1;
        r_box_y <= r_box_y + 9'd1;
      end else begin
        r_box_y <= r_box_y - 9'd1;
      end
    end
  end

  // Solid colour steps blue -> green -> red once per frame while shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_solid <= 12'h00f;
    end else if (w_frame_tick && (r_mode == MODE_SOLID)) begin
      case (r_solid)
        12'h00f: r_solid <= 12'h0f0;
        12'h0f0: r_solid <= 12'hf00;
        default: r_solid <= 12'h00f;
      endcase
    end
  end

  assign w_bar    = 3'((XW'(x_in) - XW'(1)) / XW'(80));
  assign w_x_b5   = 1'((XW'(x_in) - XW'(1)) >> 5);
  assign w_y_b5   = 1'((YW'(y_in) - YW'(1)) >> 5);
  assign w_in_box = (XW'(x_in) >= XW'(r_box_x)) &&
                    (XW'(x_in) <= XW'(r_box_x) + XW'(BOX_SIZE - 1)) &&
                    (YW'(y_in) >= YW'(r_box_y)) &&
                    (YW'(y_in) <= YW'(r_box_y) + YW'(BOX_SIZE - 1));

  // Colour for the current coordinate; blanking is always black
  always_comb begin
    w_rgb = 12'h000;
    if ((x_in != 10'd0) && (y_in != 9'd0)) begin
      case (r_mode)
        MODE_BARS:    w_rgb = {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
        MODE_CHECKER: w_rgb = (w_x_b5 ^ w_y_b5) ? 12'hfff : 12'h000;
        MODE_BOX:     w_rgb = w_in_box ? 12'hf00 : 12'h00f;
        default:      w_rgb = r_solid;
      endcase
    end
  end

  // Output register: colour and syncs advance together on pix_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
    end else if (pix_en) begin
      r_rgb <= w_rgb;
      r_hs  <= hsync_in;
      r_vs  <= vsync_in;
    end
  end

  assign VGA_HS = r_hs;
  assign VGA_VS = r_vs;
  assign VGA_R  = r_rgb[11:8];
  assign VGA_G  = r_rgb[7:4];
  assign VGA_B  = r_rgb[3:0];
  assign mode   = r_mode;

endmodule
